// File: rtl/shape_prep_sched.sv
// Round-robin scheduler that feeds dirty shape slots through the shared trig/rotate
// datapath once per frame_go and writes the settled results back to the shape file.
module shape_prep_sched #(
   parameter int MAXSHP = 16,
   parameter int IDW    = 4,
   parameter int INTW   = 16,
   parameter int FLTW   = 24,
   parameter int LAT    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_go,
   input  logic [MAXSHP-1:0] dirty_set,
   input  logic              force_all,
   output logic [IDW-1:0]    rd_id,
   input  logic [INTW-1:0]   rd_angle,
   input  logic [INTW-1:0]   rd_x,
   input  logic [INTW-1:0]   rd_y,
   output logic [INTW-1:0]   cmp_angle,
   output logic [INTW-1:0]   cmp_x0,
   output logic [INTW-1:0]   cmp_y0,
   input  logic [FLTW-1:0]   cmp_sin,
   input  logic [FLTW-1:0]   cmp_cos,
   input  logic [FLTW-1:0]   cmp_ix,
   input  logic [FLTW-1:0]   cmp_iy,
   output logic              wr_en,
   output logic [IDW-1:0]    wr_id,
   output logic [FLTW-1:0]   wr_sin,
   output logic [FLTW-1:0]   wr_cos,
   output logic [FLTW-1:0]   wr_ix,
   output logic [FLTW-1:0]   wr_iy,
   output logic              busy,
   output logic              done,
   output logic [MAXSHP-1:0] pend
);

   // Wait counter runs 0..LAT-1.
   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SEL, S_LOAD, S_WAIT, S_WRITE, S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [IDW-1:0]    rr;
   logic [IDW-1:0]    pick;
   logic [IDW-1:0]    idx;
   logic              found;
   logic [CW-1:0]     cnt;
   logic [MAXSHP-1:0] clr;
   logic [MAXSHP-1:0] pend_nxt;

   // Sets are ORed in after the clear so an edit during a shape's own WRITE survives.
   always_comb begin
      clr = '0;
      if (state == S_WRITE) clr[rr] = 1'b1;
      pend_nxt = (pend & ~clr) | dirty_set | {MAXSHP{force_all}};
   end

   // First dirty slot strictly after rr, wrapping; rr itself is checked last.
   always_comb begin
      pick  = rr;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= MAXSHP; k++) begin
         idx = IDW'((int'(rr) + k) % MAXSHP);
         if (!found && pend[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE:  if (frame_go) state_nxt = (|pend) ? S_SEL : S_DONE;
         S_SEL:   begin busy = 1'b1; state_nxt = S_LOAD; end
         S_LOAD:  begin busy = 1'b1; state_nxt = S_WAIT; end
         S_WAIT:  begin
            busy = 1'b1;
            if (cnt == CW'(LAT - 1)) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            busy      = 1'b1;
            state_nxt = (|pend_nxt) ? S_SEL : S_DONE;
         end
         S_DONE:  begin done = 1'b1; state_nxt = S_IDLE; end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         pend      <= '1;
         rr        <= IDW'(MAXSHP - 1);
         rd_id     <= '0;
         cnt       <= '0;
         cmp_angle <= '0;
         cmp_x0    <= '0;
         cmp_y0    <= '0;
         wr_en     <= 1'b0;
         wr_id     <= '0;
         wr_sin    <= '0;
         wr_cos    <= '0;
         wr_ix     <= '0;
         wr_iy     <= '0;
      end else begin
         state <= state_nxt;
         pend  <= pend_nxt;
         wr_en <= (state == S_WRITE);
         case (state)
            S_SEL: begin
               rd_id <= pick;
               rr    <= pick;
            end
            S_LOAD: begin
               cmp_angle <= rd_angle;
               cmp_x0    <= rd_x;
               cmp_y0    <= rd_y;
               cnt       <= '0;
            end
            S_WAIT:  cnt <= cnt + 1'b1;
            S_WRITE: begin
               // Strobe and data leave together on the following cycle.
               wr_id  <= rr;
               wr_sin <= cmp_sin;
               wr_cos <= cmp_cos;
               wr_ix  <= cmp_ix;
               wr_iy  <= cmp_iy;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shape_prep_sched.sv
// Randomised scoreboard bench for shape_prep_sched: a transaction-level pass model
// predicts write order, data and timing; a negedge monitor compares.
module tb_shape_prep_sched;

   localparam int MAXSHP = 16;
   localparam int IDW    = 4;
   localparam int INTW   = 16;
   localparam int FLTW   = 24;
   localparam int LAT    = 3;
   localparam int PER    = LAT + 3;
   localparam int EW     = 32 + IDW + 4 * FLTW;

   logic              clk = 1'b0;
   logic              rst;
   logic              frame_go;
   logic [MAXSHP-1:0] dirty_set;
   logic              force_all;
   logic [IDW-1:0]    rd_id;
   logic [INTW-1:0]   rd_angle, rd_x, rd_y;
   logic [INTW-1:0]   cmp_angle, cmp_x0, cmp_y0;
   logic [FLTW-1:0]   cmp_sin, cmp_cos, cmp_ix, cmp_iy;
   logic              wr_en;
   logic [IDW-1:0]    wr_id;
   logic [FLTW-1:0]   wr_sin, wr_cos, wr_ix, wr_iy;
   logic              busy, done;
   logic [MAXSHP-1:0] pend;

   logic [INTW-1:0] s_angle [MAXSHP];
   logic [INTW-1:0] s_x     [MAXSHP];
   logic [INTW-1:0] s_y     [MAXSHP];

   logic [EW-1:0] exp_q[$];
   int            exp_done_q[$];
   logic [MAXSHP-1:0] m_pend;
   int            m_rr;
   int            cyc = 0;
   int            n_vec = 0;
   int            n_err = 0;

   shape_prep_sched #(.MAXSHP(MAXSHP), .IDW(IDW), .INTW(INTW), .FLTW(FLTW), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .frame_go(frame_go), .dirty_set(dirty_set), .force_all(force_all),
      .rd_id(rd_id), .rd_angle(rd_angle), .rd_x(rd_x), .rd_y(rd_y),
      .cmp_angle(cmp_angle), .cmp_x0(cmp_x0), .cmp_y0(cmp_y0),
      .cmp_sin(cmp_sin), .cmp_cos(cmp_cos), .cmp_ix(cmp_ix), .cmp_iy(cmp_iy),
      .wr_en(wr_en), .wr_id(wr_id), .wr_sin(wr_sin), .wr_cos(wr_cos), .wr_ix(wr_ix), .wr_iy(wr_iy),
      .busy(busy), .done(done), .pend(pend)
   );

   function automatic logic [FLTW-1:0] f_sin(input logic [INTW-1:0] a);
      return {a[15:8], a} ^ 24'h5A0000;
   endfunction
   function automatic logic [FLTW-1:0] f_cos(input logic [INTW-1:0] a);
      return {a, a[7:0]} + 24'd7;
   endfunction
   function automatic logic [FLTW-1:0] f_ix(input logic [INTW-1:0] x, input logic [INTW-1:0] y);
      return {x[7:0], y};
   endfunction
   function automatic logic [FLTW-1:0] f_iy(input logic [INTW-1:0] x, input logic [INTW-1:0] y);
      return {y[11:0], x[11:0]};
   endfunction

   // Register file and trig/rotate datapath stand-ins.
   assign rd_angle = s_angle[rd_id];
   assign rd_x     = s_x[rd_id];
   assign rd_y     = s_y[rd_id];
   assign cmp_sin  = f_sin(cmp_angle);
   assign cmp_cos  = f_cos(cmp_angle);
   assign cmp_ix   = f_ix(cmp_x0, cmp_y0);
   assign cmp_iy   = f_iy(cmp_x0, cmp_y0);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [EW-1:0] pack(input int c, input int id);
      return {32'(c), IDW'(id), f_sin(s_angle[id]), f_cos(s_angle[id]),
              f_ix(s_x[id], s_y[id]), f_iy(s_x[id], s_y[id])};
   endfunction

   // One pass as a list of services; inj_mask lands during the WRITE of service inj_at.
   task automatic model_pass(input int c0, input logic [MAXSHP-1:0] inj_mask, input int inj_at,
                             output int done_cyc);
      int i;
      int cur;
      bit hit;
      i = 0;
      while (m_pend != 0 && i < 64) begin
         hit = 0;
         cur = m_rr;
         for (int k = 1; k <= MAXSHP; k++) begin
            int j;
            j = (m_rr + k) % MAXSHP;
            if (!hit && m_pend[j]) begin
               cur = j;
               hit = 1;
            end
         end
         m_rr = cur;
         m_pend[cur] = 1'b0;
         if (i == inj_at) m_pend = m_pend | inj_mask;
         exp_q.push_back(pack(c0 + PER * (i + 1) + 1, cur));
         i++;
      end
      done_cyc = c0 + PER * i + 1;
      exp_done_q.push_back(done_cyc);
   endtask

   task automatic randomize_file();
      for (int i = 0; i < MAXSHP; i++) begin
         s_angle[i] = INTW'($urandom_range(0, 65535));
         s_x[i]     = INTW'($urandom_range(0, 65535));
         s_y[i]     = INTW'($urandom_range(0, 65535));
      end
   endtask

   task automatic mark(input logic [MAXSHP-1:0] mask, input bit force_it);
      tick();
      dirty_set = mask;
      force_all = force_it;
      m_pend = m_pend | mask | {MAXSHP{force_it}};
      tick();
      dirty_set = '0;
      force_all = 1'b0;
   endtask

   task automatic run_pass(input logic [MAXSHP-1:0] inj_mask, input int inj_at,
                           input bit hold_chk, input logic [INTW-1:0] hold_val, input bit busy_go);
      int c0;
      int dc;
      tick();
      rst      = 1'b0;
      frame_go = 1'b1;
      c0       = cyc;
      model_pass(c0, inj_mask, inj_at, dc);
      tick();
      frame_go = 1'b0;
      while (cyc < dc + 3) begin
         tick();
         dirty_set = (inj_at >= 0 && cyc == c0 + PER * (inj_at + 1)) ? inj_mask : '0;
         frame_go  = busy_go && (cyc == c0 + 3);
         if (hold_chk && cyc >= c0 + 3 && cyc <= c0 + PER)
            chk("cmp_angle_hold", cmp_angle, hold_val);
      end
      dirty_set = '0;
      frame_go  = 1'b0;
      chk("pend_after_pass", pend, m_pend);
      chk("writes_left", exp_q.size(), 0);
      chk("dones_left", exp_done_q.size(), 0);
      exp_q.delete();
      exp_done_q.delete();
   endtask

   always @(negedge clk) begin
      logic [EW-1:0] e;
      int dc;
      if (wr_en) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_wr_en", {1'b1, wr_id}, '0);
         end else begin
            e = exp_q.pop_front();
            chk("wr_cycle", cyc, e[EW-1:EW-32]);
            chk("wr_id", wr_id, e[EW-33:4*FLTW]);
            chk("wr_data", {wr_sin, wr_cos, wr_ix, wr_iy}, e[4*FLTW-1:0]);
         end
      end
      if (done) begin
         if (exp_done_q.size() == 0) begin
            chk("unexpected_done", cyc, '0);
         end else begin
            dc = exp_done_q.pop_front();
            chk("done_cycle", cyc, dc);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      logic [MAXSHP-1:0] mask;
      logic [MAXSHP-1:0] inj;
      int inj_at;
      int cnt;
      rst       = 1'b1;
      frame_go  = 1'b0;
      dirty_set = '0;
      force_all = 1'b0;
      randomize_file();
      tick();
      tick();
      tick();
      chk("rst_rd_id", rd_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_pend", pend, 16'hFFFF);
      chk("rst_cmp", {cmp_angle, cmp_x0, cmp_y0}, 0);
      chk("rst_wr", {wr_id, wr_sin, wr_cos, wr_ix, wr_iy}, 0);
      m_pend = '1;
      m_rr   = MAXSHP - 1;

      // First pass after reset: every slot, ids 0..15.
      run_pass('0, -1, 1'b0, '0, 1'b0);

      // Nothing pending: done alone.
      run_pass('0, -1, 1'b0, '0, 1'b0);

      // Ids 2 and 15, negative angle held through WAIT, stray frame_go while busy.
      s_angle[2] = 16'hFFA6;
      mark(16'h8004, 1'b0);
      run_pass('0, -1, 1'b1, 16'hFFA6, 1'b1);

      // Id 5 re-dirtied during its own WRITE.
      mark(16'h0FF0, 1'b0);
      run_pass(16'h0020, 1, 1'b0, '0, 1'b0);

      // Slot behind the pointer dirtied at rr=9: serviced after the wrap.
      mark(16'h9700, 1'b0);
      run_pass(16'h0008, 1, 1'b0, '0, 1'b0);

      for (int p = 0; p < 8; p++) begin
         randomize_file();
         mask = MAXSHP'($urandom_range(0, 65535));
         mark(mask, $urandom_range(0, 7) == 0);
         cnt    = $countones(m_pend);
         inj    = MAXSHP'($urandom_range(0, 65535)) & MAXSHP'($urandom_range(0, 65535));
         inj_at = (cnt > 0) ? $urandom_range(0, cnt - 1) : -1;
         run_pass(inj, inj_at, 1'b0, '0, $urandom_range(0, 1) == 1);
      end

      // Reset during WAIT aborts the pass with no write.
      mark(16'h0300, 1'b0);
      tick();
      frame_go = 1'b1;
      c0       = cyc;
      tick();
      frame_go = 1'b0;
      while (cyc < c0 + 4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_pend", pend, 16'hFFFF);
      chk("abort_wr_en", wr_en, 0);
      chk("abort_done", done, 0);
      m_pend = '1;
      m_rr   = MAXSHP - 1;
      for (int i = 0; i < 10; i++) tick();

      randomize_file();
      run_pass('0, -1, 1'b0, '0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
